fma_arb: RTL and testbench
==========================

FMA_ARB -- requirements
Module: fma_arb

Interface
REQ-001 SHALL have parameter LAT, default 4, meaning the FMA pipeline depth in cycles from issue to result (legal 2..8).
REQ-002 SHALL have parameter TAGW, default 5, meaning the requester tag width (destination register id).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous and active-high.
REQ-005 SHALL have ports Req0Valid/Req1Valid, input, 1 each, meaning an FMA op is offered by requester 0 (FPU main pipe) or 1 (auxiliary unit).
REQ-006 SHALL have ports Req0Tag/Req1Tag, input, TAGW each, meaning the tag carried with each op.
REQ-007 SHALL have ports Req0Ready/Req1Ready, output, 1 each, meaning the op is accepted this cycle when Valid is also high.
REQ-008 SHALL have port FmaIssue, output, 1, meaning the FMA stage-1 registers load this cycle.
REQ-009 SHALL have port FmaSel, output, 1, meaning the operand mux selects requester 1 (0 = requester 0).
REQ-010 SHALL have port FmaStall, output, 1, meaning all FMA pipeline registers hold this cycle.
REQ-011 SHALL have ports Rsp0Valid/Rsp1Valid, output, 1 each, and Rsp0Ready/Rsp1Ready, input, 1 each, for the result handshake per requester.
REQ-012 SHALL have port RspTag, output, TAGW, meaning the tag of the op in the last stage.
REQ-013 SHALL have port Flush0, input, 1, meaning all requester-0 ops in flight are cancelled.
REQ-014 SHALL have port InFlight, output, $clog2(LAT+1), meaning the count of valid pipeline slots.

Function
REQ-015 SHALL track LAT slots, each holding {valid, owner, tag}; slot LAT-1 drives Rsp*Valid and RspTag.
REQ-016 SHALL assert FmaStall exactly when slot LAT-1 is valid and its owner's RspReady is low.
REQ-017 SHALL, when not stalled, shift all slots by one per cycle and load slot 0 with the granted op, or with valid=0 when no grant.
REQ-018 SHALL hold all slots and deassert both ReqReady while FmaStall is high.
REQ-019 SHALL arbitrate round-robin: when both Valid, grant the requester not granted most recently; when one Valid, grant it.
REQ-020 SHALL raise ReqReady combinationally only for the granted requester; FmaIssue = grant & ~FmaStall; FmaSel = owner of the grant.
REQ-021 SHALL give latency exactly LAT cycles from acceptance to RspValid absent stalls; each stall cycle adds one cycle.
REQ-022 SHALL assert Rsp0Valid only for an owner-0 final slot and Rsp1Valid only for owner-1; never both.
REQ-023 SHALL, on Flush0, clear valid of every owner-0 slot at the clock edge, including slot LAT-1, and deassert Req0Ready that cycle.
REQ-024 SHALL, when Flush0 coincides with a stall on an owner-0 final slot, deassert FmaStall that same cycle.
REQ-025 SHALL leave owner-1 slots and the round-robin pointer unchanged by Flush0.
REQ-026 SHALL compute InFlight as the population count of slot valid bits, in the range 0..LAT.

Reset
REQ-027 SHALL, on reset, clear all slot valids, set the round-robin pointer so requester 0 wins the first conflict, and zero the slot tags.
REQ-028 SHALL drive during reset: FmaIssue=0, FmaStall=0, Rsp*Valid=0, Req*Ready=0, InFlight=0, and discard in-flight ops.

Structure
REQ-029 SHALL place the slot record typedef {valid, owner, tag} and the owner encoding constants in the shared FPU package.
REQ-030 SHALL use one sub-module, fma_rrarb (2-input round-robin arbiter with pointer register); the slot pipeline is inline.

Verification
REQ-031 SHALL cover this scenario: LAT=4, single Req0 op tag 5 at cycle 0 with Rsp0Ready=1 -> Rsp0Valid=1 with RspTag=5 at cycle 4 only; InFlight=1 during cycles 1-4.
REQ-032 SHALL cover this scenario: both Valid for 4 cycles, tags 0x10/0x11 -> grants alternate 0,1,0,1; responses in the same order.
REQ-033 SHALL cover this scenario: Rsp1Ready=0 for 3 cycles on an owner-1 final slot -> FmaStall=1 and ReqReady=0 for 3 cycles, slot contents unchanged, response delivered on release.
REQ-034 SHALL cover this scenario: ops owner 0,1,0 in flight, Flush0 pulse -> InFlight drops 3->1, only the owner-1 response appears.
REQ-035 SHALL cover this scenario: Flush0 during a stall on an owner-0 final slot -> FmaStall=0 that cycle and no Rsp0Valid.
REQ-036 SHALL cover this scenario: reset asserted mid-flight with InFlight=3 -> all outputs zero immediately; first post-reset conflict grants requester 0.

Source files
------------

// File: rtl/fma_arb_pkg.sv
// fma_arb_pkg: shared slot record, owner encoding and response-ready helper for the FMA issue arbiter
package fma_arb_pkg;

    localparam int TAG_MAX = 8;
    localparam logic OWN0 = 1'b0;
    localparam logic OWN1 = 1'b1;

    typedef struct packed {
        logic               valid;
        logic               owner;
        logic [TAG_MAX-1:0] tag;
    } slot_t;

    function automatic logic rsp_ready(input logic owner, input logic r0, input logic r1);
        return (owner == OWN1) ? r1 : r0;
    endfunction

endpackage

// File: rtl/fma_arb_if.sv
// fma_arb_if: requester, FMA control and response signals of the FMA issue arbiter
interface fma_arb_if #(
    parameter int LAT  = 4,
    parameter int TAGW = 5
);
    logic                       Req0Valid, Req1Valid;
    logic [TAGW-1:0]            Req0Tag, Req1Tag;
    logic                       Req0Ready, Req1Ready;
    logic                       FmaIssue, FmaSel, FmaStall;
    logic                       Rsp0Valid, Rsp1Valid;
    logic                       Rsp0Ready, Rsp1Ready;
    logic [TAGW-1:0]            RspTag;
    logic                       Flush0;
    logic [$clog2(LAT+1)-1:0]   InFlight;

    modport slave (
        input  Req0Valid, Req1Valid, Req0Tag, Req1Tag, Rsp0Ready, Rsp1Ready, Flush0,
        output Req0Ready, Req1Ready, FmaIssue, FmaSel, FmaStall, Rsp0Valid, Rsp1Valid, RspTag, InFlight
    );

    modport master (
        output Req0Valid, Req1Valid, Req0Tag, Req1Tag, Rsp0Ready, Rsp1Ready, Flush0,
        input  Req0Ready, Req1Ready, FmaIssue, FmaSel, FmaStall, Rsp0Valid, Rsp1Valid, RspTag, InFlight
    );

endinterface

// File: rtl/fma_rrarb.sv
// fma_rrarb: two-input round-robin arbiter; pointer remembers the last requester actually issued
module fma_rrarb
    import fma_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       adv,
    output logic       gnt,
    output logic       owner
);
    logic last;

    always_comb begin
        gnt   = |req;
        owner = (&req) ? ~last : req[1];
    end

    // starting as if requester 1 went last lets requester 0 win the first conflict
    always_ff @(posedge clk or posedge reset) begin
        if (reset) last <= OWN1;
        else if (adv) last <= owner;
    end

endmodule

// File: rtl/fma_arb.sv
// fma_arb: round-robin issue into a LAT-deep FMA pipeline with per-slot owner/tag tracking,
// backpressure stall from the final slot and requester-0 flush
module fma_arb
    import fma_arb_pkg::*;
#(
    parameter int LAT  = 4,
    parameter int TAGW = 5
) (
    input logic      clk,
    input logic      reset,
    fma_arb_if.slave bus
);
    localparam int CW = $clog2(LAT + 1);

    slot_t         slots [LAT];
    slot_t         nxt   [LAT];
    logic          gnt, own, live, stall, issue;
    logic [CW-1:0] cnt;

    fma_rrarb u_rr (
        .clk   (clk),
        .reset (reset),
        .req   ({bus.Req1Valid, bus.Req0Valid & ~bus.Flush0}),
        .adv   (issue),
        .gnt   (gnt),
        .owner (own)
    );

    always_comb begin
        // a flushed owner-0 final slot no longer counts, so it cannot stall
        live   = slots[LAT-1].valid & ~(bus.Flush0 & (slots[LAT-1].owner == OWN0));
        stall  = live & ~rsp_ready(slots[LAT-1].owner, bus.Rsp0Ready, bus.Rsp1Ready);
        issue  = gnt & ~stall & ~reset;
        nxt[0] = stall ? slots[0] : slot_t'{issue, own, TAG_MAX'(own ? bus.Req1Tag : bus.Req0Tag)};
        for (int i = 1; i < LAT; i++) nxt[i] = stall ? slots[i] : slots[i-1];
        cnt = '0;
        for (int i = 0; i < LAT; i++) begin
            if (bus.Flush0 && nxt[i].owner == OWN0) nxt[i].valid = 1'b0;
            cnt = cnt + CW'(slots[i].valid);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) for (int i = 0; i < LAT; i++) slots[i] <= '0;
        else slots <= nxt;
    end

    assign bus.Req0Ready = issue & (own == OWN0);
    assign bus.Req1Ready = issue & (own == OWN1);
    assign bus.FmaIssue  = issue;
    assign bus.FmaSel    = own;
    assign bus.FmaStall  = stall;
    assign bus.Rsp0Valid = live & (slots[LAT-1].owner == OWN0);
    assign bus.Rsp1Valid = live & (slots[LAT-1].owner == OWN1);
    assign bus.RspTag    = slots[LAT-1].tag[TAGW-1:0];
    assign bus.InFlight  = cnt;

endmodule

// File: tb/tb_fma_arb.sv
// tb_fma_arb: directed scenarios for fma_arb with a queue scoreboard checked by a response monitor
module tb_fma_arb;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fma_arb_if #(.LAT(4), .TAGW(5)) bus ();
    fma_arb #(.LAT(4), .TAGW(5)) dut (.clk(clk), .reset(reset), .bus(bus));

    int vectors = 0;
    int miscompares = 0;
    logic [5:0] q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // offer one cycle of requests; g is the requester expected to win (-1 for none)
    task automatic op(input logic v0, input logic v1, input logic [4:0] t0, input logic [4:0] t1, input int g);
        bus.Req0Valid = v0;
        bus.Req1Valid = v1;
        bus.Req0Tag   = t0;
        bus.Req1Tag   = t1;
        @(negedge clk);
        chk("req0_ready", bus.Req0Ready, g == 0);
        chk("req1_ready", bus.Req1Ready, g == 1);
        chk("fma_issue", bus.FmaIssue, g >= 0);
        if (g >= 0) begin
            chk("fma_sel", bus.FmaSel, g[0]);
            q.push_back({g[0], (g == 1) ? t1 : t0});
        end
        cyc();
        bus.Req0Valid = 1'b0;
        bus.Req1Valid = 1'b0;
    endtask

    function automatic void drop0();
        logic [5:0] k[$];
        foreach (q[i]) if (q[i][5]) k.push_back(q[i]);
        q = k;
    endfunction

    always @(negedge clk) begin
        if (bus.Rsp0Valid && bus.Rsp1Valid) begin
            vectors++;
            miscompares++;
            $display("FAIL rsp_both: got both valid expected one at %0t", $time);
        end
        if ((bus.Rsp0Valid && bus.Rsp0Ready) || (bus.Rsp1Valid && bus.Rsp1Ready)) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL rsp_unexpected: got %0h expected none at %0t", {bus.Rsp1Valid, bus.RspTag}, $time);
            end else begin
                logic [5:0] e;
                e = q.pop_front();
                if ({bus.Rsp1Valid, bus.RspTag} !== e) begin
                    miscompares++;
                    $display("FAIL rsp_order: got %0h expected %0h at %0t", {bus.Rsp1Valid, bus.RspTag}, e, $time);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.Req0Valid = 1'b1;
        bus.Req1Valid = 1'b0;
        bus.Req0Tag   = '0;
        bus.Req1Tag   = '0;
        bus.Rsp0Ready = 1'b1;
        bus.Rsp1Ready = 1'b1;
        bus.Flush0    = 1'b0;
        @(negedge clk);
        chk("rst_req0_ready", bus.Req0Ready, 0);
        chk("rst_issue", bus.FmaIssue, 0);
        chk("rst_stall", bus.FmaStall, 0);
        chk("rst_rsp0", bus.Rsp0Valid, 0);
        chk("rst_rsp1", bus.Rsp1Valid, 0);
        chk("rst_inflight", bus.InFlight, 0);
        cyc();
        reset = 1'b0;
        bus.Req0Valid = 1'b0;

        // single op, latency 4
        op(1, 0, 5'd5, 5'd0, 0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("s1_inflight", bus.InFlight, 1);
            chk("s1_rsp0", bus.Rsp0Valid, c == 4);
            cyc();
        end
        @(negedge clk);
        chk("s1_inflight_end", bus.InFlight, 0);
        chk("s1_rsp0_end", bus.Rsp0Valid, 0);
        cyc();

        // back-to-back conflicts alternate starting with requester 0
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) op(1, 1, 5'h10, 5'h11, k % 2);
        repeat (6) cyc();
        @(negedge clk);
        chk("s2_inflight", bus.InFlight, 0);
        cyc();

        // three-cycle stall on an owner-1 final slot
        bus.Rsp1Ready = 1'b0;
        op(0, 1, 5'd0, 5'd7, 1);
        repeat (3) cyc();
        for (int k = 0; k < 3; k++) begin
            bus.Req0Valid = 1'b1;
            bus.Req0Tag   = 5'd9;
            @(negedge clk);
            chk("s3_stall", bus.FmaStall, 1);
            chk("s3_req0_ready", bus.Req0Ready, 0);
            chk("s3_rsp1", bus.Rsp1Valid, 1);
            chk("s3_tag", bus.RspTag, 7);
            chk("s3_inflight", bus.InFlight, 1);
            cyc();
        end
        bus.Req0Valid = 1'b0;
        bus.Rsp1Ready = 1'b1;
        @(negedge clk);
        chk("s3_release", bus.FmaStall, 0);
        cyc();

        // flush with owners 0,1,0 in flight
        op(1, 0, 5'd1, 5'd0, 0);
        op(0, 1, 5'd0, 5'd2, 1);
        op(1, 0, 5'd3, 5'd0, 0);
        bus.Flush0    = 1'b1;
        bus.Req0Valid = 1'b1;
        bus.Req0Tag   = 5'd9;
        drop0();
        @(negedge clk);
        chk("s4_inflight_pre", bus.InFlight, 3);
        chk("s4_req0_ready", bus.Req0Ready, 0);
        chk("s4_issue", bus.FmaIssue, 0);
        cyc();
        bus.Flush0    = 1'b0;
        bus.Req0Valid = 1'b0;
        @(negedge clk);
        chk("s4_inflight_post", bus.InFlight, 1);
        cyc();
        repeat (4) cyc();

        // flush while stalled on an owner-0 final slot
        bus.Rsp0Ready = 1'b0;
        op(1, 0, 5'h0A, 5'd0, 0);
        repeat (3) cyc();
        @(negedge clk);
        chk("s5_stall", bus.FmaStall, 1);
        chk("s5_rsp0", bus.Rsp0Valid, 1);
        cyc();
        bus.Flush0 = 1'b1;
        drop0();
        @(negedge clk);
        chk("s5_stall_flush", bus.FmaStall, 0);
        chk("s5_rsp0_flush", bus.Rsp0Valid, 0);
        cyc();
        bus.Flush0    = 1'b0;
        bus.Rsp0Ready = 1'b1;
        @(negedge clk);
        chk("s5_inflight", bus.InFlight, 0);
        chk("s5_rsp0_after", bus.Rsp0Valid, 0);
        cyc();

        // reset mid-flight, then first conflict must go to requester 0
        op(0, 1, 5'd0, 5'd1, 1);
        op(0, 1, 5'd0, 5'd2, 1);
        op(1, 0, 5'd3, 5'd0, 0);
        @(negedge clk);
        chk("s6_inflight_pre", bus.InFlight, 3);
        cyc();
        bus.Req0Valid = 1'b1;
        bus.Req1Valid = 1'b1;
        reset = 1'b1;
        q.delete();
        #1;
        chk("s6_inflight", bus.InFlight, 0);
        chk("s6_stall", bus.FmaStall, 0);
        chk("s6_rsp0", bus.Rsp0Valid, 0);
        chk("s6_rsp1", bus.Rsp1Valid, 0);
        chk("s6_req0_ready", bus.Req0Ready, 0);
        chk("s6_req1_ready", bus.Req1Ready, 0);
        chk("s6_issue", bus.FmaIssue, 0);
        cyc();
        reset = 1'b0;
        op(1, 1, 5'h15, 5'h16, 0);

        for (int k = 0; k < 20 && q.size() != 0; k++) cyc();
        chk("drain", q.size(), 0);
        @(negedge clk);
        chk("final_inflight", bus.InFlight, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
